// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the two-requester data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int unsigned NUM_REQ = 2;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // A byte pair is unusable if misaligned, outside memory, or straddling the top byte.
    function automatic logic addr_rejected(input logic [31:0] addr, input int unsigned mem_bytes);
        return addr[0] || (addr >= mem_bytes) || (addr == mem_bytes - 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side req/ack bus of the data-memory arbiter (one instance per requester).
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, we, addr, wdata, input ack, rdata, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way picker: a lone request wins; on a tie the pointer side wins unless m0 has fixed priority.
module rr_arb2
    import dmem_arb_pkg::*;
#(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_ptr,
    output logic               o_gnt,
    output logic               o_valid
);

    always_comb begin
        o_valid = |i_req;
        o_gnt   = 1'b0;
        case (i_req)
            2'b01:   o_gnt = 1'b0;
            2'b10:   o_gnt = 1'b1;
            2'b11:   o_gnt = PRIO_FIXED ? 1'b0 : i_ptr;
            default: o_gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer between two requesters and a single-port 16-bit data memory.
// Define DMEM_ARB_CHECK_EN to reject misaligned / out-of-range accesses with err.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MEM_BYTES  = 256,
    parameter bit          PRIO_FIXED = 1'b0
) (
    input  logic              clk_pi,
    input  logic              reset_pi,
    input  logic              clk_en_pi,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic              mem_write_po,
    output logic [ADDR_W-1:0] mem_addr_po,
    output logic [DATA_W-1:0] mem_wdata_po,
    input  logic [DATA_W-1:0] mem_rdata_pi,
    output logic              busy_po,
    output logic              last_gnt_po
);

`ifdef DMEM_ARB_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    state_t             r_state;
    logic               r_ptr;
    logic               r_win;
    logic               r_we;
    logic               r_reject;
    logic               r_mem_write;
    logic               r_last_gnt;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_err;
    logic [DATA_W-1:0]  r_rdata [NUM_REQ];

    logic [NUM_REQ-1:0] w_req;
    logic               w_gnt;
    logic               w_gnt_valid;
    logic               w_we_sel;
    logic               w_reject;
    logic [ADDR_W-1:0]  w_addr_sel;
    logic [DATA_W-1:0]  w_wdata_sel;

    assign w_req = {m1.req, m0.req};

    rr_arb2 #(.PRIO_FIXED(PRIO_FIXED)) u_rr_arb2 (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_valid (w_gnt_valid)
    );

    assign w_we_sel    = w_gnt ? m1.we    : m0.we;
    assign w_addr_sel  = w_gnt ? m1.addr  : m0.addr;
    assign w_wdata_sel = w_gnt ? m1.wdata : m0.wdata;
    // Address is frozen from grant to response, so judging it at grant equals judging it in ACCESS.
    assign w_reject    = CHECK_EN && addr_rejected(32'(w_addr_sel), MEM_BYTES);

    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 1'b0;
            r_win       <= 1'b0;
            r_we        <= 1'b0;
            r_reject    <= 1'b0;
            r_mem_write <= 1'b0;
            r_last_gnt  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ack       <= '0;
            r_err       <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_rdata[i] <= '0;
            end
        end else if (clk_en_pi) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_win       <= w_gnt;
                        r_last_gnt  <= w_gnt;
                        r_ptr       <= ~w_gnt;
                        r_we        <= w_we_sel;
                        r_reject    <= w_reject;
                        r_mem_addr  <= w_addr_sel;
                        r_mem_wdata <= w_wdata_sel;
                        r_mem_write <= (w_we_sel == OP_WR) && !w_reject;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_mem_write  <= 1'b0;
                    r_ack[r_win] <= 1'b1;
                    r_err[r_win] <= r_reject;
                    if (r_reject) begin
                        r_rdata[r_win] <= '0;
                    end else if (r_we == OP_RD) begin
                        r_rdata[r_win] <= mem_rdata_pi;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_ack   <= '0;
                    r_err   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_write_po = r_mem_write;
    assign mem_addr_po  = r_mem_addr;
    assign mem_wdata_po = r_mem_wdata;
    assign busy_po      = (r_state != ST_IDLE);
    assign last_gnt_po  = r_last_gnt;

    assign m0.ack   = r_ack[0];
    assign m0.err   = r_err[0];
    assign m0.rdata = r_rdata[0];
    assign m1.ack   = r_ack[1];
    assign m1.err   = r_err[1];
    assign m1.rdata = r_rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic vs a byte-array model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    logic mem_init;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) m0_if ();
    dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) m1_if ();
    dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) m0f_if ();
    dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) m1f_if ();

    logic        mem_write, busy, last_gnt;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        f_mem_write, f_busy, f_last_gnt;
    logic [15:0] f_mem_addr, f_mem_wdata, f_mem_rdata;
    logic        f_clk_en;

    assign f_mem_rdata = 16'h1234;
    assign f_clk_en    = 1'b1;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_BYTES(256), .PRIO_FIXED(1'b0)) dut (
        .clk_pi(clk), .reset_pi(rst), .clk_en_pi(clk_en),
        .m0(m0_if), .m1(m1_if),
        .mem_write_po(mem_write), .mem_addr_po(mem_addr), .mem_wdata_po(mem_wdata),
        .mem_rdata_pi(mem_rdata), .busy_po(busy), .last_gnt_po(last_gnt)
    );

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_BYTES(256), .PRIO_FIXED(1'b1)) dut_fx (
        .clk_pi(clk), .reset_pi(rst), .clk_en_pi(f_clk_en),
        .m0(m0f_if), .m1(m1f_if),
        .mem_write_po(f_mem_write), .mem_addr_po(f_mem_addr), .mem_wdata_po(f_mem_wdata),
        .mem_rdata_pi(f_mem_rdata), .busy_po(f_busy), .last_gnt_po(f_last_gnt)
    );

    // Memory the DUT talks to: 256 bytes, big-endian pairs, address wraps at 8 bits.
    logic [7:0] tb_mem [256];
    logic [7:0] ma0, ma1;
    assign ma0       = mem_addr[7:0];
    assign ma1       = ma0 + 8'd1;
    assign mem_rdata = {tb_mem[ma0], tb_mem[ma1]};

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= 8'(i * 7 + 3);
        end else if (mem_write) begin
            tb_mem[ma0] <= mem_wdata[15:8];
            tb_mem[ma1] <= mem_wdata[7:0];
        end
    end

    // Reference contents, updated in the order the bench expects accesses to be served.
    logic [7:0] ref_mem [256];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic bit rejected(input logic [15:0] a);
        return CHECK && (a[0] || (a >= 16'd256) || (a == 16'd255));
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {ref_mem[b], ref_mem[8'(b + 8'd1)]};
    endfunction

    task automatic ref_write(input logic [15:0] a, input logic [15:0] d);
        logic [7:0] b;
        b = a[7:0];
        ref_mem[b]              = d[15:8];
        ref_mem[8'(b + 8'd1)]   = d[7:0];
    endtask

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [15:0] a, input logic [15:0] d);
        if (p == 0) begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = a; m0_if.wdata = d;
        end else begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = a; m1_if.wdata = d;
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? m0_if.ack : m1_if.ack;
    endfunction
    function automatic logic err_of(input int p);
        return (p == 0) ? m0_if.err : m1_if.err;
    endfunction
    function automatic logic [15:0] rdata_of(input int p);
        return (p == 0) ? m0_if.rdata : m1_if.rdata;
    endfunction

    task automatic test_reset();
        rst = 1'b1; mem_init = 1'b1; clk_en = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        m0f_if.req = 1'b0; m0f_if.we = 1'b0; m0f_if.addr = 16'h0; m0f_if.wdata = 16'h0;
        m1f_if.req = 1'b0; m1f_if.we = 1'b0; m1f_if.addr = 16'h0; m1f_if.wdata = 16'h0;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        n_tests++;
        if ({mem_write, busy, last_gnt, m0_if.ack, m1_if.ack, m0_if.err, m1_if.err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {mem_write, busy, last_gnt, m0_if.ack, m1_if.ack, m0_if.err, m1_if.err});
        end
        n_tests++;
        if ({mem_addr, mem_wdata, m0_if.rdata, m1_if.rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0",
                     {mem_addr, mem_wdata, m0_if.rdata, m1_if.rdata});
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_write_latency();
        drive(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        @(negedge clk);
        n_tests++;
        if ({mem_write, busy, m0_if.ack, mem_addr, mem_wdata} !== {3'b110, 16'h0010, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL wr_access: got %h expected %h",
                     {mem_write, busy, m0_if.ack, mem_addr, mem_wdata}, {3'b110, 16'h0010, 16'hBEEF});
        end
        @(negedge clk);
        n_tests++;
        if ({m0_if.ack, m0_if.err, mem_write, m1_if.ack} !== 4'b1000) begin
            n_fail++;
            $display("FAIL wr_ack_n2: got %b expected 1000", {m0_if.ack, m0_if.err, mem_write, m1_if.ack});
        end
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        ref_write(16'h0010, 16'hBEEF);
        @(negedge clk);
        n_tests++;
        if ({m0_if.ack, busy} !== 2'b00) begin
            n_fail++; $display("FAIL wr_ack_pulse: got %b expected 00", {m0_if.ack, busy});
        end
    endtask

    task automatic test_read();
        int  lat;
        bit  m0_seen;
        lat = -1; m0_seen = 0;
        drive(1, 1'b1, 1'b0, 16'h0010, 16'h0);
        for (int k = 0; k < 8 && lat < 0; k++) begin
            @(negedge clk);
            if (m0_if.ack) m0_seen = 1;
            if (m1_if.ack) lat = k;
        end
        n_tests++;
        if (lat !== 1 || m1_if.rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rd_m1: got lat=%0d rdata=%h expected lat=1 rdata=beef", lat, m1_if.rdata);
        end
        n_tests++;
        if (m0_seen !== 1'b0) begin
            n_fail++; $display("FAIL rd_m0_quiet: got m0 ack %b expected 0", m0_seen);
        end
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
    endtask

    task automatic test_alternate();
        int         seq_main[$];
        int         seq_fx[$];
        logic [3:0] g_main, g_fx;
        bit         m1f_seen;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 16'h0040, 16'h0);
        drive(1, 1'b1, 1'b0, 16'h0042, 16'h0);
        m0f_if.req = 1'b1; m1f_if.req = 1'b1;
        m1f_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m0_if.ack)  seq_main.push_back(0);
            if (m1_if.ack)  seq_main.push_back(1);
            if (m0f_if.ack) seq_fx.push_back(0);
            if (m1f_if.ack) m1f_seen = 1;
        end
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        m0f_if.req = 1'b0; m1f_if.req = 1'b0;
        g_main = 4'bxxxx; g_fx = 4'bxxxx;
        for (int i = 0; i < 4; i++) begin
            if (i < seq_main.size()) g_main[3-i] = seq_main[i][0];
            if (i < seq_fx.size())   g_fx[3-i]   = seq_fx[i][0];
        end
        n_tests++;
        if (g_main !== 4'b0101) begin
            n_fail++; $display("FAIL rr_alternate: got %b expected 0101", g_main);
        end
        n_tests++;
        if (g_fx !== 4'b0000 || m1f_seen !== 1'b0) begin
            n_fail++; $display("FAIL fixed_prio: got %b m1=%b expected 0000 m1=0", g_fx, m1f_seen);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_clk_en_stall();
        int ack_k, wr_cycles, rises, ack_cycles;
        bit prev_w, addr_ok;
        ack_k = -1; wr_cycles = 0; rises = 0; ack_cycles = 0; prev_w = 0; addr_ok = 1;
        drive(0, 1'b1, 1'b1, 16'h0020, 16'hA55A);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_write) begin
                wr_cycles++;
                if (!prev_w) rises++;
                if (mem_addr !== 16'h0020) addr_ok = 0;
            end
            prev_w = mem_write;
            if (m0_if.ack) ack_cycles++;
            if (m0_if.ack && ack_k < 0) begin
                ack_k = k;
                drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
            end
            if (k == 1) clk_en = 1'b0;
            if (k == 4) clk_en = 1'b1;
        end
        ref_write(16'h0020, 16'hA55A);
        n_tests++;
        if (ack_k !== 5 || ack_cycles !== 1) begin
            n_fail++; $display("FAIL stall_ack: got at %0d x%0d expected at 5 x1", ack_k, ack_cycles);
        end
        n_tests++;
        if (wr_cycles !== 4 || rises !== 1 || addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_write: got cycles=%0d pulses=%0d addr_ok=%0b expected 4 1 1",
                     wr_cycles, rises, addr_ok);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] old30, exp44;
        bit          quiet;
        int          got;
        old30 = ref_read(16'h0030);
        exp44 = ref_read(16'h0044);
        drive(0, 1'b1, 1'b1, 16'h0030, 16'h1357);
        @(negedge clk);
        n_tests++;
        if (mem_write !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: got %b expected 1", mem_write);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({mem_write, busy, last_gnt, m0_if.ack, m1_if.ack, mem_addr, mem_wdata, m0_if.rdata} !== 69'h0) begin
            n_fail++;
            $display("FAIL rstmid_zero: got %h expected 0",
                     {mem_write, busy, last_gnt, m0_if.ack, m1_if.ack, mem_addr, mem_wdata, m0_if.rdata});
        end
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 1;
        repeat (4) begin
            @(negedge clk);
            if (m0_if.ack || m1_if.ack) quiet = 0;
        end
        n_tests++;
        if (quiet !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_noack: got ack seen expected none");
        end
        drive(0, 1'b1, 1'b0, 16'h0030, 16'h0);
        drive(1, 1'b1, 1'b0, 16'h0044, 16'h0);
        for (int n = 0; n < 2; n++) begin
            got = -1;
            for (int k = 0; k < 10 && got < 0; k++) begin
                @(negedge clk);
                if (m0_if.ack) got = 0;
                else if (m1_if.ack) got = 1;
            end
            n_tests++;
            if (got !== n || (got == 0 && m0_if.rdata !== old30) || (got == 1 && m1_if.rdata !== exp44)) begin
                n_fail++;
                $display("FAIL rstmid_after%0d: got port %0d rdata %h/%h expected port %0d rdata %h/%h",
                         n, got, m0_if.rdata, m1_if.rdata, n, old30, exp44);
            end
            if (got >= 0) drive(got, 1'b0, 1'b0, 16'h0, 16'h0);
        end
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
    endtask

    task automatic test_check();
        logic [15:0] addrs [4];
        logic        wr, ack, err, we;
        logic [15:0] d, exp_rd;
        bit          rej;
        addrs[0] = 16'h0011; addrs[1] = 16'h00FF; addrs[2] = 16'h00FE; addrs[3] = 16'h00FF;
        for (int i = 0; i < 4; i++) begin
            we     = (i < 3);
            d      = 16'($urandom);
            rej    = rejected(addrs[i]);
            exp_rd = rej ? 16'h0 : ref_read(addrs[i]);
            drive(0, 1'b1, we, addrs[i], d);
            @(negedge clk);
            wr = mem_write;
            @(negedge clk);
            ack = m0_if.ack; err = m0_if.err;
            drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
            if (we && !rej) ref_write(addrs[i], d);
            n_tests++;
            if ({wr, ack, err} !== {we & ~rej, 1'b1, rej}) begin
                n_fail++;
                $display("FAIL check_%h: got wr/ack/err %b expected %b", addrs[i], {wr, ack, err},
                         {we & ~rej, 1'b1, rej});
            end
            if (!we) begin
                n_tests++;
                if (m0_if.rdata !== exp_rd) begin
                    n_fail++; $display("FAIL check_rd_%h: got %h expected %h", addrs[i], m0_if.rdata, exp_rd);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        bit          pend [2];
        logic        pwe  [2];
        logic [15:0] padr [2];
        logic [15:0] pdat [2];
        logic [15:0] hold [2];
        int          fav, exp_p, got_p;
        logic [15:0] exp_rd;
        bit          exp_err, abort;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fav = 0; abort = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; hold[p] = 16'h0;
        end
        for (int t = 0; t < 200 && !abort; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(0, 3) != 0 || (p == 1 && !pend[0]))) begin
                    pend[p] = 1;
                    pwe[p]  = 1'($urandom_range(0, 1));
                    padr[p] = 16'($urandom_range(0, 255));
                    if ($urandom_range(0, 9) == 0) padr[p] = 16'($urandom);
                    pdat[p] = 16'($urandom);
                    drive(p, 1'b1, pwe[p], padr[p], pdat[p]);
                end
            end
            if (pend[0] && pend[1]) exp_p = fav;
            else exp_p = pend[1] ? 1 : 0;
            fav     = 1 - exp_p;
            exp_err = rejected(padr[exp_p]);
            if (exp_err) hold[exp_p] = 16'h0;
            else if (!pwe[exp_p]) hold[exp_p] = ref_read(padr[exp_p]);
            else ref_write(padr[exp_p], pdat[exp_p]);
            exp_rd = hold[exp_p];
            got_p = -1;
            for (int k = 0; k < 12 && got_p < 0; k++) begin
                @(negedge clk);
                if (m0_if.ack && m1_if.ack) got_p = 2;
                else if (m0_if.ack) got_p = 0;
                else if (m1_if.ack) got_p = 1;
            end
            n_tests++;
            if (got_p !== exp_p) begin
                n_fail++;
                $display("FAIL rnd_gnt[%0d]: got port %0d expected port %0d", t, got_p, exp_p);
                abort = 1;
            end else begin
                n_tests++;
                if ({err_of(exp_p), rdata_of(exp_p), last_gnt} !== {exp_err, exp_rd, exp_p[0]}) begin
                    n_fail++;
                    $display("FAIL rnd_resp[%0d]: got err=%b rdata=%h gnt=%b expected err=%b rdata=%h gnt=%b",
                             t, err_of(exp_p), rdata_of(exp_p), last_gnt, exp_err, exp_rd, exp_p[0]);
                end
                pend[exp_p] = 0;
                drive(exp_p, 1'b0, 1'b0, 16'h0, 16'h0);
            end
        end
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_read();
        test_alternate();
        test_clk_en_stall();
        test_reset_mid_access();
        test_check();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish by 300000");
        $fatal(1, "watchdog");
    end

endmodule
